// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS controller.
package mips_multicycle_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned STATE_W = 4;

  // Opcodes
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  // Mux selects
  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMMSH   = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // Control word produced per state; alu_en qualifies alucontrol.
  typedef struct packed {
    logic       memreq;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alu_en;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_aludec.sv
// ALU decoder: maps aluop/funct to the 3-bit ALU control code.
module mips_multicycle_ctrl_aludec
  import mips_multicycle_ctrl_pkg::*;
(
  input  aluop_t            i_aluop,
  input  logic [FUNCT_W-1:0] i_funct,
  output logic [ALU_W-1:0]   o_alucontrol
);

  // Pure combinational decode; unknown funct falls back to add.
  always_comb begin
    o_alucontrol = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alucontrol = ALU_ADD;
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alucontrol = ALU_ADD;
          FN_SUB:  o_alucontrol = ALU_SUB;
          FN_AND:  o_alucontrol = ALU_AND;
          FN_OR:   o_alucontrol = ALU_OR;
          FN_SLT:  o_alucontrol = ALU_SLT;
          default: o_alucontrol = ALU_ADD;
        endcase
      end
      default: o_alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencing controller: Moore FSM with memory handshake stalls.
// Outputs are decoded from the current state (plus memready/zero gating) and
// are held at zero while reset_n is low so no request reaches memory.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               memready,
  output logic               memreq,
  output logic               memwrite,
  output logic               iord,
  output logic               irwrite,
  output logic               pcen,
  output logic [1:0]         pcsrc,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic [ALU_W-1:0]   alucontrol,
  output logic               illegal
);

  state_t            r_state;
  state_t            w_next;
  ctrl_t             w_ctrl;
  aluop_t            w_aluop;
  logic [ALU_W-1:0]  w_alu;

  mips_multicycle_ctrl_aludec u_aludec (
    .i_aluop      (w_aluop),
    .i_funct      (funct),
    .o_alucontrol (w_alu)
  );

  // State register; reset parks the FSM in FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // Next-state and per-state control word.
  always_comb begin
    w_next  = S_FETCH;
    w_ctrl  = '0;
    w_aluop = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_ctrl.memreq  = 1'b1;
        w_ctrl.alusrcb = SRCB_FOUR;
        w_ctrl.pcsrc   = PCSRC_ALURES;
        w_ctrl.alu_en  = 1'b1;
        w_ctrl.irwrite = memready;
        w_ctrl.pcen    = memready;
        w_next         = memready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_ctrl.alusrcb = SRCB_IMMSH;
        w_ctrl.alu_en  = 1'b1;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next         = S_FETCH;
            w_ctrl.illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_IMM;
        w_ctrl.alu_en  = 1'b1;
        w_next         = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_ctrl.memreq = 1'b1;
        w_ctrl.iord   = 1'b1;
        w_next        = memready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_ctrl.memtoreg = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_next          = S_FETCH;
      end
      S_MEMWR: begin
        w_ctrl.memreq   = 1'b1;
        w_ctrl.memwrite = 1'b1;
        w_ctrl.iord     = 1'b1;
        w_next          = memready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_REG;
        w_ctrl.alu_en  = 1'b1;
        w_aluop        = ALUOP_FUNCT;
        w_next         = S_ALUWB;
      end
      S_ALUWB: begin
        w_ctrl.regdst   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_next          = S_FETCH;
      end
      S_BRANCH: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_REG;
        w_ctrl.alu_en  = 1'b1;
        w_ctrl.pcsrc   = PCSRC_ALUOUT;
        w_ctrl.pcen    = zero;
        w_aluop        = ALUOP_SUB;
        w_next         = S_FETCH;
      end
      S_ADDIEX: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_IMM;
        w_ctrl.alu_en  = 1'b1;
        w_next         = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_ctrl.regwrite = 1'b1;
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        w_ctrl.pcsrc = PCSRC_JUMP;
        w_ctrl.pcen  = 1'b1;
        w_next       = S_FETCH;
      end
      default: begin
        w_ctrl = '0;
        w_next = S_FETCH;
      end
    endcase
  end

  // Drive ports; everything is forced low while reset is asserted.
  always_comb begin
    memreq     = reset_n & w_ctrl.memreq;
    memwrite   = reset_n & w_ctrl.memwrite;
    iord       = reset_n & w_ctrl.iord;
    irwrite    = reset_n & w_ctrl.irwrite;
    pcen       = reset_n & w_ctrl.pcen;
    pcsrc      = reset_n ? w_ctrl.pcsrc : 2'b00;
    alusrca    = reset_n & w_ctrl.alusrca;
    alusrcb    = reset_n ? w_ctrl.alusrcb : 2'b00;
    regdst     = reset_n & w_ctrl.regdst;
    memtoreg   = reset_n & w_ctrl.memtoreg;
    regwrite   = reset_n & w_ctrl.regwrite;
    alucontrol = (reset_n && w_ctrl.alu_en) ? w_alu : ALU_W'(0);
    illegal    = reset_n & w_ctrl.illegal;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl; each cycle's full control word is
// compared against a hand-derived constant.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       memreq, memwrite, iord, irwrite, pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       regdst, memtoreg, regwrite;
  logic [2:0] alucontrol;
  logic       illegal;

  int n_tests = 0;
  int n_fail  = 0;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memready   (memready),
    .memreq     (memreq),
    .memwrite   (memwrite),
    .iord       (iord),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .pcsrc      (pcsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Bit order: memreq memwrite iord irwrite pcen pcsrc[2] alusrca alusrcb[2]
  //            regdst memtoreg regwrite alucontrol[3] illegal
  localparam logic [16:0] E_ZERO   = 17'b0_0_0_0_0_00_0_00_0_0_0_000_0;
  localparam logic [16:0] E_FRDY   = 17'b1_0_0_1_1_00_0_01_0_0_0_010_0;
  localparam logic [16:0] E_FWAIT  = 17'b1_0_0_0_0_00_0_01_0_0_0_010_0;
  localparam logic [16:0] E_DEC    = 17'b0_0_0_0_0_00_0_11_0_0_0_010_0;
  localparam logic [16:0] E_DECILL = 17'b0_0_0_0_0_00_0_11_0_0_0_010_1;
  localparam logic [16:0] E_ADR    = 17'b0_0_0_0_0_00_1_10_0_0_0_010_0;
  localparam logic [16:0] E_MRD    = 17'b1_0_1_0_0_00_0_00_0_0_0_000_0;
  localparam logic [16:0] E_MWB    = 17'b0_0_0_0_0_00_0_00_0_1_1_000_0;
  localparam logic [16:0] E_MWR    = 17'b1_1_1_0_0_00_0_00_0_0_0_000_0;
  localparam logic [16:0] E_EXSLT  = 17'b0_0_0_0_0_00_1_00_0_0_0_111_0;
  localparam logic [16:0] E_EXDEF  = 17'b0_0_0_0_0_00_1_00_0_0_0_010_0;
  localparam logic [16:0] E_ALUWB  = 17'b0_0_0_0_0_00_0_00_1_0_1_000_0;
  localparam logic [16:0] E_BR1    = 17'b0_0_0_0_1_01_1_00_0_0_0_110_0;
  localparam logic [16:0] E_BR0    = 17'b0_0_0_0_0_01_1_00_0_0_0_110_0;
  localparam logic [16:0] E_ADDIWB = 17'b0_0_0_0_0_00_0_00_0_0_1_000_0;
  localparam logic [16:0] E_JUMP   = 17'b0_0_0_0_1_10_0_00_0_0_0_000_0;

  // Check the current cycle mid-period, then advance to just after the next edge.
  task automatic step(input string tag, input logic [16:0] exp);
    logic [16:0] obs;
    @(negedge clk);
    obs = {memreq, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
           regdst, memtoreg, regwrite, alucontrol, illegal};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    op       = 6'b000000;
    funct    = 6'b000000;
    zero     = 1'b0;
    memready = 1'b0;
    step("rst0", E_ZERO);
    step("rst1", E_ZERO);

    // First request right after release; memready low keeps FETCH waiting.
    reset_n = 1'b1;
    step("fetch_wait", E_FWAIT);

    // lw up to a waiting MEMRD, then reset for 3 cycles mid-access.
    op = 6'b100011; memready = 1'b1;
    step("lwa_fetch", E_FRDY);
    step("lwa_dec", E_DEC);
    step("lwa_adr", E_ADR);
    memready = 1'b0;
    step("lwa_rd_wait", E_MRD);
    reset_n = 1'b0;
    step("rst_mid0", E_ZERO);
    step("rst_mid1", E_ZERO);
    step("rst_mid2", E_ZERO);
    reset_n = 1'b1;
    step("rel_fetch", E_FWAIT);

    // lw with zero wait states: 5 cycles.
    memready = 1'b1;
    step("lw_fetch", E_FRDY);
    step("lw_dec", E_DEC);
    step("lw_adr", E_ADR);
    step("lw_rd", E_MRD);
    step("lw_wb", E_MWB);

    // sw with 3 wait cycles in MEMWR.
    op = 6'b101011;
    step("sw_fetch", E_FRDY);
    step("sw_dec", E_DEC);
    step("sw_adr", E_ADR);
    memready = 1'b0;
    step("sw_wr_w0", E_MWR);
    step("sw_wr_w1", E_MWR);
    step("sw_wr_w2", E_MWR);
    memready = 1'b1;
    step("sw_wr_done", E_MWR);

    // beq taken then not taken.
    op = 6'b000100; zero = 1'b1;
    step("beq1_fetch", E_FRDY);
    step("beq1_dec", E_DEC);
    step("beq1_br", E_BR1);
    zero = 1'b0;
    step("beq0_fetch", E_FRDY);
    step("beq0_dec", E_DEC);
    step("beq0_br", E_BR0);

    // R-type slt, then R-type with unknown funct.
    op = 6'b000000; funct = 6'b101010;
    step("slt_fetch", E_FRDY);
    step("slt_dec", E_DEC);
    step("slt_ex", E_EXSLT);
    step("slt_wb", E_ALUWB);
    funct = 6'b000000;
    step("rdef_fetch", E_FRDY);
    step("rdef_dec", E_DEC);
    step("rdef_ex", E_EXDEF);
    step("rdef_wb", E_ALUWB);

    // addi: 4 cycles.
    op = 6'b001000;
    step("addi_fetch", E_FRDY);
    step("addi_dec", E_DEC);
    step("addi_ex", E_ADR);
    step("addi_wb", E_ADDIWB);

    // j: 3 cycles.
    op = 6'b000010;
    step("j_fetch", E_FRDY);
    step("j_dec", E_DEC);
    step("j_jump", E_JUMP);

    // Illegal op: single pulse in DECODE, then back to FETCH.
    op = 6'b111111;
    step("ill_fetch", E_FRDY);
    step("ill_dec", E_DECILL);
    memready = 1'b0;
    step("ill_back", E_FWAIT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
